// File: rtl/prbs_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_ctrl_pkg
// Brief    : Shared types and constants for the PRBS run controller.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int C_DEFAULT_CNT_W = 16;

  // Sliced down to the counter width by users; all-ones marks "no detection".
  localparam logic [63:0] C_FIRST_HIT_NONE = '1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat = &r_count;

  // Next value is exported so callers can judge a result that includes
  // an increment landing on the same edge.
  always_comb begin
    count_nxt = r_count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && !w_sat) begin
      count_nxt = r_count + C_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_count <= '0;
    end else begin
      r_count <= count_nxt;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/prbs_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prbs_run_ctrl
// Brief    : Sequences a PRBS/pattern-detector datapath through one test run.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_run_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int CNT_W    = C_DEFAULT_CNT_W,
  parameter int MIN_HITS = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [7:0]       n_cfg,
  input  logic [CNT_W-1:0] run_len,
  input  logic             pattern_detected,
  output logic             dp_rstn,
  output logic [31:0]      dp_in,
  output logic [7:0]       dp_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] first_hit
);

  localparam logic [CNT_W-1:0] C_NONE     = C_FIRST_HIT_NONE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_MIN_HITS = CNT_W'(MIN_HITS);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_load_cnt;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_first_hit;
  logic [31:0]      r_dp_in;
  logic [7:0]       r_dp_n;
  logic             r_dp_rstn;
  logic             r_pass;
  logic             r_aborted;
  logic [CNT_W-1:0] w_hits_nxt;
  logic             w_accept;
  logic             w_finish;
  logic             w_hit_inc;
  logic             w_last_cyc;

  assign w_last_cyc = (r_cyc == (r_run_len - C_ONE));
  assign w_hit_inc  = (r_state == ST_RUN) && pattern_detected;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_accept    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
        end else if (r_load_cnt) begin
          w_state_nxt = (r_run_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort || w_last_cyc) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_finish = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath reset is registered from the next state so it tracks LOAD
  // exactly and releases on the first edge after RSTn deasserts.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dp_rstn  <= 1'b0;
      r_load_cnt <= 1'b0;
      r_cyc      <= '0;
      r_run_len  <= '0;
      r_dp_in    <= '0;
      r_dp_n     <= '0;
    end else begin
      r_dp_rstn  <= (w_state_nxt != ST_LOAD);
      r_load_cnt <= (r_state == ST_LOAD) ? ~r_load_cnt : 1'b0;
      r_cyc      <= (r_state == ST_RUN) ? (r_cyc + C_ONE) : '0;
      if (w_accept) begin
        r_run_len <= run_len;
        r_dp_in   <= seed;
        r_dp_n    <= n_cfg;
      end
    end
  end

  // Abort overrides the hit count even on the final RUN cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pass      <= 1'b0;
      r_aborted   <= 1'b0;
      r_first_hit <= C_NONE;
    end else begin
      if (w_accept) begin
        r_pass    <= 1'b0;
        r_aborted <= 1'b0;
      end else if (w_finish) begin
        r_aborted <= abort;
        r_pass    <= !abort && (w_hits_nxt >= C_MIN_HITS);
      end
      if (w_accept) begin
        r_first_hit <= C_NONE;
      end else if (w_hit_inc && (hit_cnt == '0)) begin
        r_first_hit <= r_cyc;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .clr       (w_accept),
    .inc       (w_hit_inc),
    .count     (hit_cnt),
    .count_nxt (w_hits_nxt)
  );

  assign dp_rstn   = r_dp_rstn;
  assign dp_in     = r_dp_in;
  assign dp_n      = r_dp_n;
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign aborted   = r_aborted;
  assign first_hit = r_first_hit;

endmodule
`default_nettype wire

// File: tb/tb_prbs_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_run_ctrl
// Brief    : Directed, scoreboarded bench for prbs_run_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_run_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    int          k;
    logic [15:0] hits;
    logic [15:0] first;
    logic        pass;
    logic        aborted;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] seed = '0;
  logic [7:0]  n_cfg = '0;
  logic [15:0] run_len = '0;
  logic        pattern_detected = 1'b0;
  logic        dp_rstn;
  logic [31:0] dp_in;
  logic [7:0]  dp_n;
  logic        busy;
  logic        done;
  logic        pass;
  logic        aborted;
  logic [15:0] hit_cnt;
  logic [15:0] first_hit;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  prbs_run_ctrl #(
    .CNT_W    (CNT_W),
    .MIN_HITS (1)
  ) dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .start            (start),
    .abort            (abort),
    .seed             (seed),
    .n_cfg            (n_cfg),
    .run_len          (run_len),
    .pattern_detected (pattern_detected),
    .dp_rstn          (dp_rstn),
    .dp_in            (dp_in),
    .dp_n             (dp_n),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .aborted          (aborted),
    .hit_cnt          (hit_cnt),
    .first_hit        (first_hit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_done"},    32'(done),      32'd0);
    check({tag, "_dprstn"},  32'(dp_rstn),   32'd0);
    check({tag, "_dpin"},    dp_in,          32'd0);
    check({tag, "_dpn"},     32'(dp_n),      32'd0);
    check({tag, "_pass"},    32'(pass),      32'd0);
    check({tag, "_aborted"}, 32'(aborted),   32'd0);
    check({tag, "_hits"},    32'(hit_cnt),   32'd0);
    check({tag, "_first"},   32'(first_hit), 32'hFFFF);
  endtask

  // Called on a negedge with the DUT idle. Negedge k after the accepting
  // edge observes: k=1,2 LOAD, k=3+i RUN cycle i, then DONE.
  task automatic run_case(input string name, input logic [31:0] s, input logic [7:0] n,
                          input int len, input int hit_a, input int hit_b,
                          input bit hold_all, input int abort_at);
    exp_t e;
    exp_t g;
    bit   ab;
    bit   seen;
    int   end_idx;
    int   cnt;
    int   first;
    int   hits[2];
    ab      = (abort_at >= 0) && (abort_at < len);
    end_idx = ab ? abort_at : len - 1;
    cnt     = 0;
    first   = 'hFFFF;
    if (hold_all) begin
      cnt   = (end_idx + 1 > 65535) ? 65535 : end_idx + 1;
      first = (end_idx >= 0) ? 0 : 'hFFFF;
    end else begin
      hits[0] = hit_a;
      hits[1] = hit_b;
      foreach (hits[j]) begin
        if (hits[j] >= 0 && hits[j] <= end_idx) begin
          cnt++;
          if (hits[j] < first) first = hits[j];
        end
      end
    end
    e.k       = ab ? 4 + abort_at : 3 + len;
    e.hits    = cnt[15:0];
    e.first   = first[15:0];
    e.pass    = !ab && (cnt >= 1);
    e.aborted = ab;
    sb.push_back(e);

    start            = 1'b1;
    seed             = s;
    n_cfg            = n;
    run_len          = len[15:0];
    pattern_detected = hold_all;
    seen             = 1'b0;
    for (int k = 1; k <= len + 12 && !seen; k++) begin
      @(negedge CLK);
      start   = 1'b0;
      seed    = $urandom;
      n_cfg   = 8'($urandom);
      run_len = 16'($urandom);
      if (k == 1) begin
        check({name, "_load_busy"},   32'(busy),      32'd1);
        check({name, "_load_dprstn"}, 32'(dp_rstn),   32'd0);
        check({name, "_load_hits"},   32'(hit_cnt),   32'd0);
        check({name, "_load_first"},  32'(first_hit), 32'hFFFF);
        check({name, "_load_pass"},   32'(pass),      32'd0);
        check({name, "_load_abort"},  32'(aborted),   32'd0);
      end
      if (k == 2) check({name, "_load2_dprstn"}, 32'(dp_rstn), 32'd0);
      if (k == 3) check({name, "_post_dprstn"},  32'(dp_rstn), 32'd1);
      if (done) begin
        seen = 1'b1;
        g = sb.pop_front();
        check({name, "_done_cycle"}, k,               g.k);
        check({name, "_hits"},       32'(hit_cnt),    32'(g.hits));
        check({name, "_first"},      32'(first_hit),  32'(g.first));
        check({name, "_pass"},       32'(pass),       32'(g.pass));
        check({name, "_aborted"},    32'(aborted),    32'(g.aborted));
        check({name, "_dpin"},       dp_in,           s);
        check({name, "_dpn"},        32'(dp_n),       32'(n));
      end else if (k >= 3) begin
        pattern_detected = hold_all || (k - 3 == hit_a) || (k - 3 == hit_b);
        abort            = (k - 3 == abort_at);
      end
    end
    pattern_detected = 1'b0;
    abort            = 1'b0;
    if (!seen) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge CLK);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_done"}, 32'(done), 32'd0);
    check({name, "_idle_pass"}, 32'(pass), 32'(e.pass));
  endtask

  initial begin
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RSTn = 1'b1;
    #1;
    check("por_rel_dprstn", 32'(dp_rstn), 32'd0);
    @(negedge CLK);
    check("por_first_edge_dprstn", 32'(dp_rstn), 32'd1);

    // Abort while idle must not start anything.
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_done", 32'(done), 32'd0);

    run_case("basic",     32'h0000_0001, 8'd7,  100,   10, 40, 1'b0, -1);
    run_case("nohit",     32'hA5A5_0003, 8'd15, 50,    -1, -1, 1'b0, -1);
    run_case("abort",     32'h1234_5678, 8'd23, 100,   2,  -1, 1'b0, 5);
    run_case("abortlast", 32'h0BAD_F00D, 8'd31, 8,     7,  -1, 1'b0, 7);
    run_case("zero",      32'hFFFF_FFFF, 8'd9,  0,     -1, -1, 1'b0, -1);
    run_case("edges",     32'h5555_AAAA, 8'd11, 20,    0,  19, 1'b0, -1);

    // Restart attempts mid-run are ignored; reset at RUN cycle 20 kills the run.
    start   = 1'b1;
    seed    = 32'hCAFE_0001;
    n_cfg   = 8'd5;
    run_len = 16'd100;
    for (int k = 1; k <= 23; k++) begin
      @(negedge CLK);
      if (k == 13) begin
        check("rst_run_hits",  32'(hit_cnt),   32'd1);
        check("rst_run_first", 32'(first_hit), 32'd2);
        check("rst_run_busy",  32'(busy),      32'd1);
      end
      start            = (k == 6) || (k == 7);
      pattern_detected = (k == 5);
    end
    pattern_detected = 1'b0;
    RSTn = 1'b0;
    #1;
    check_reset_values("midrun");
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("midrun_no_done", 32'(done), 32'd0);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    check("midrun_rel_dprstn", 32'(dp_rstn), 32'd1);
    check("midrun_rel_done",   32'(done),    32'd0);
    check("midrun_rel_busy",   32'(busy),    32'd0);

    run_case("sat", 32'h0F0F_0F0F, 8'd7, 65535, -1, -1, 1'b1, -1);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_run_ctrl.md
PRBS_RUN_CTRL -- requirements
Module: prbs_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of run-length and hit counters.
REQ-002 Parameter MIN_HITS, default 1, detections required for a passing run.
REQ-003 CLK  input  1  sole clock; all state on rising edge.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-006 abort  input  1  terminates an active run.
REQ-007 seed  input  32  PRBS seed, captured on accepted start.
REQ-008 n_cfg  input  8  PRBS length select, captured on accepted start.
REQ-009 run_len  input  CNT_W  run length in RUN cycles, captured on accepted start.
REQ-010 pattern_detected  input  1  detector flag from PRBS/pattern-detector datapath.
REQ-011 dp_rstn  output  1  active-low reset to datapath (PRBS generator and detector).
REQ-012 dp_in  output  32  seed to datapath `in` port.
REQ-013 dp_n  output  8  length select to datapath `n` port.
REQ-014 busy  output  1  high in LOAD and RUN.
REQ-015 done  output  1  one-cycle pulse on entry to DONE.
REQ-016 pass  output  1  result of last run; valid from done until next accepted start.
REQ-017 aborted  output  1  last run ended by abort; same validity as pass.
REQ-018 hit_cnt  output  CNT_W  detections counted in last/current run.
REQ-019 first_hit  output  CNT_W  RUN-cycle index of first detection; all-ones if none.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-021 IDLE -> LOAD when start=1; capture seed, n_cfg, run_len into registers driving dp_in, dp_n, run limit.
REQ-022 LOAD SHALL last exactly 2 cycles with dp_rstn=0 so the datapath loads the captured seed; then -> RUN.
REQ-023 dp_rstn=1 in RUN, IDLE, DONE; dp_rstn=0 only in LOAD.
REQ-024 RUN: cycle counter starts at 0 on first RUN cycle, increments each cycle; RUN -> DONE on the cycle counter==run_len-1.
REQ-025 run_len=0: LOAD -> DONE directly, hit_cnt=0, first_hit all-ones.
REQ-026 Each RUN cycle with pattern_detected=1 SHALL increment hit_cnt by 1, saturating at all-ones.
REQ-027 First RUN cycle with pattern_detected=1 SHALL load first_hit with current cycle counter; later hits leave it unchanged.
REQ-028 pattern_detected SHALL be ignored outside RUN.
REQ-029 abort=1 in LOAD or RUN -> DONE next cycle, aborted=1, pass=0; abort in IDLE/DONE ignored.
REQ-030 abort and final RUN cycle coincident: abort wins (aborted=1, pass=0); a hit in that same cycle is still counted.
REQ-031 Normal completion: pass=1 iff hit_cnt (including hit on final RUN cycle) >= MIN_HITS.
REQ-032 DONE SHALL last one cycle (done=1), then -> IDLE.
REQ-033 start outside IDLE SHALL be ignored, no queuing.
REQ-034 On accepted start, hit_cnt, first_hit, pass, aborted SHALL clear in the LOAD entry cycle.
REQ-035 dp_in, dp_n SHALL hold captured values until next accepted start.

Reset
REQ-036 RSTn low SHALL immediately force state IDLE, dp_rstn=0, dp_in=0, dp_n=0, busy=0, done=0, pass=0, aborted=0, hit_cnt=0, first_hit=all-ones.
REQ-037 After RSTn release, dp_rstn SHALL go 1 on the first clock edge in IDLE.
REQ-038 Reset mid-RUN SHALL discard the run; no done pulse is generated.

Structure
REQ-039 Package prbs_ctrl_pkg SHALL hold the state enum, default CNT_W, and the first_hit "none" constant.
REQ-040 Sub-module sat_counter (parameterised width, clear, increment, saturate) SHALL implement hit_cnt; cycle counter is inline.

Verification
REQ-041 seed=32'h0000_0001, n_cfg=8'd7, run_len=100, detector driven high on RUN cycles 10 and 40 -> done after 2+100 cycles, hit_cnt=2, first_hit=10, pass=1.
REQ-042 run_len=50, no detections, MIN_HITS=1 -> hit_cnt=0, first_hit=16'hFFFF, pass=0, aborted=0.
REQ-043 abort at RUN cycle 5 of run_len=100 -> done 1 cycle later, aborted=1, pass=0, busy low after DONE.
REQ-044 run_len=0 -> LOAD 2 cycles, done, hit_cnt=0, pass=0 (MIN_HITS=1).
REQ-045 start pulses during RUN and RSTn asserted at RUN cycle 20 -> extra starts ignored; on reset all outputs at REQ-036 values, no done pulse.
REQ-046 pattern_detected held high for full run_len=16'hFFFF with CNT_W=16 -> hit_cnt saturates at 16'hFFFF, pass=1.
